// File: rtl/elevator_ctrl_if.sv
// Call-button / car-status bundle between the call panel and the elevator controller.
interface elevator_ctrl_if #(
    parameter int NUM_FLOORS = 4
);
    localparam int IDX_W = $clog2(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] call_req;   // per-floor call buttons
    logic [NUM_FLOORS-1:0] floor;      // one-hot current floor
    logic [IDX_W-1:0]      floor_idx;  // binary current floor
    logic                  moving;     // car in motion
    logic                  dir_up;     // 1 = up / preferred up
    logic                  door_open;  // door open command
    logic [NUM_FLOORS-1:0] pending;    // latched, unserved calls

    // Call panel side: drives buttons, observes car status.
    modport master (
        output call_req,
        input  floor, floor_idx, moving, dir_up, door_open, pending
    );

    // Controller side: samples buttons, drives car status.
    modport slave (
        input  call_req,
        output floor, floor_idx, moving, dir_up, door_open, pending
    );
endinterface

// File: rtl/elevator_ctrl.sv
// N-floor elevator controller: latches calls, moves one floor per TRAVEL_CYCLES
// clocks, holds the door open DOOR_OPEN_CYCLES clocks at each requested floor.
module elevator_ctrl #(
    parameter int NUM_FLOORS       = 4,
    parameter int TRAVEL_CYCLES    = 4,
    parameter int DOOR_OPEN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    elevator_ctrl_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_FLOORS);
    localparam int MAX_CNT = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int TIMER_W = $clog2(MAX_CNT + 1);

    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_OPEN_CYCLES - 1);
    // A re-press at the open floor counts its own cycle as the first of the renewed window.
    localparam logic [TIMER_W-1:0] EXT_RESTART = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      floor_idx_q, floor_idx_d;
    logic [NUM_FLOORS-1:0] floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic                  moving_q, moving_d;
    logic                  door_open_q, door_open_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    logic [NUM_FLOORS-1:0] req;
    logic [IDX_W-1:0]      step_idx;

    // Any request strictly above idx.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] r, input logic [IDX_W-1:0] idx);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(idx) && r[i]) any_above = 1'b1;
        end
    endfunction

    // Any request strictly below idx.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] r, input logic [IDX_W-1:0] idx);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(idx) && r[i]) any_below = 1'b1;
        end
    endfunction

    // Live button presses are visible to decisions in the same cycle they arrive.
    assign req      = pending_q | bus.call_req;
    assign step_idx = dir_up_q ? floor_idx_q + 1'b1 : floor_idx_q - 1'b1;

    // State register: all state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            floor_idx_q <= '0;
            floor_q     <= NUM_FLOORS'(1);
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            timer_q     <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            floor_idx_q <= floor_idx_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
        end
    end

    // Next-state logic: scheduling, travel timing, door timing, call latching.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d     = state_q;
        floor_idx_d = floor_idx_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (req[floor_idx_q]) begin
                    state_d = S_DOOR;
                end else if (dir_up_q ? any_above(req, floor_idx_q) : any_below(req, floor_idx_q)) begin
                    state_d = S_MOVE;
                end else if (dir_up_q ? any_below(req, floor_idx_q) : any_above(req, floor_idx_q)) begin
                    // Nothing left ahead (always true at an end floor): turn toward the interior.
                    dir_up_d = ~dir_up_q;
                    state_d  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d     = '0;
                    floor_idx_d = step_idx;
                    if (req[step_idx]) begin
                        state_d = S_DOOR;
                    end else if (!(dir_up_q ? any_above(req, step_idx) : any_below(req, step_idx))) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DOOR: begin
                if (bus.call_req[floor_idx_q]) begin
                    timer_d = EXT_RESTART;
                end else if (timer_q >= DOOR_LAST) begin
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Latch new calls; the floor being opened (or held open) is served, and that wins.
        pending_d = pending_q | bus.call_req;
        if (state_d == S_DOOR) pending_d[floor_idx_d] = 1'b0;
    end

    // Output decode: derived from the next state so the outputs leave flops.
    always_comb begin
        moving_d             = (state_d == S_MOVE);
        door_open_d          = (state_d == S_DOOR);
        floor_d              = '0;
        floor_d[floor_idx_d] = 1'b1;
    end

    assign bus.floor     = floor_q;
    assign bus.floor_idx = floor_idx_q;
    assign bus.moving    = moving_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.door_open = door_open_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios plus random traffic,
// with a queue of expected door-open floors checked on each door opening.
module tb_elevator_ctrl;
    localparam int N           = 4;
    localparam int TRAVEL      = 4;
    localparam int DOOR        = 3;
    localparam int SERVE_BOUND = 2 * N * (TRAVEL + DOOR);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    elevator_ctrl_if #(.NUM_FLOORS(N)) bus ();

    elevator_ctrl #(
        .NUM_FLOORS      (N),
        .TRAVEL_CYCLES   (TRAVEL),
        .DOOR_OPEN_CYCLES(DOOR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_q[$];
    logic       prev_door = 1'b0;
    bit         sb_strict = 1'b1;
    logic [N-1:0] outstanding = '0;
    int         age[N];

    // Advance one cycle, sample at the falling edge, check invariants and the scoreboard.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.door_open && bus.moving) begin
            n_errors++;
            $display("FAIL door_and_moving: door_open=%0b moving=%0b, required not both 1", bus.door_open, bus.moving);
        end
        n_checks++;
        if (!$onehot(bus.floor) || bus.floor !== (N'(1) << bus.floor_idx)) begin
            n_errors++;
            $display("FAIL floor_onehot: floor=%b floor_idx=%0d, required one-hot matching idx", bus.floor, bus.floor_idx);
        end
        if (bus.door_open && !prev_door) begin
            if (exp_q.size() > 0) begin
                int e;
                e = exp_q.pop_front();
                n_checks++;
                if (int'(bus.floor_idx) !== e) begin
                    n_errors++;
                    $display("FAIL sb_open_floor: opened at %0d, required %0d", bus.floor_idx, e);
                end
            end else if (sb_strict) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected_open: door opened at %0d, required no opening", bus.floor_idx);
            end
        end
        prev_door = bus.door_open;
        for (int i = 0; i < N; i++) begin
            if (bus.door_open && int'(bus.floor_idx) == i) begin
                outstanding[i] = 1'b0;
                age[i] = 0;
            end else if (outstanding[i]) begin
                age[i]++;
                if (age[i] > SERVE_BOUND) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL serve_latency: floor %0d waited %0d cycles, required <= %0d", i, age[i], SERVE_BOUND);
                    outstanding[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.call_req = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.call_req = '1;   // must be ignored while reset is asserted
        step();
        step();
        n_checks++;
        if (bus.floor !== 4'b0001 || bus.floor_idx !== 2'd0 || bus.moving !== 1'b0 ||
            bus.dir_up !== 1'b1 || bus.door_open !== 1'b0 || bus.pending !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_state: floor=%b idx=%0d mov=%0b up=%0b door=%0b pend=%b, required 0001/0/0/1/0/0000",
                     bus.floor, bus.floor_idx, bus.moving, bus.dir_up, bus.door_open, bus.pending);
        end
        rst_n = 1'b1;
        bus.call_req = '0;
        step();
        n_checks++;
        if (bus.moving !== 1'b0 || bus.door_open !== 1'b0 || bus.pending !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_release_idle: mov=%0b door=%0b pend=%b, required 0/0/0000", bus.moving, bus.door_open, bus.pending);
        end
    endtask

    task automatic test_call_at_floor();
        bus.call_req = 4'b0001;
        exp_q.push_back(0);
        step();
        bus.call_req = '0;
        for (int k = 1; k <= DOOR + 1; k++) begin
            n_checks++;
            if (bus.door_open !== (k <= DOOR) || bus.moving !== 1'b0 || bus.pending[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL call_at_floor_c%0d: door=%0b mov=%0b pend0=%0b, required %0b/0/0",
                         k, bus.door_open, bus.moving, bus.pending[0], (k <= DOOR));
            end
            if (k <= DOOR) step();
        end
    endtask

    task automatic test_travel();
        bus.call_req = 4'b0100;
        exp_q.push_back(2);
        for (int k = 1; k <= 2 * TRAVEL; k++) begin
            step();
            bus.call_req = '0;
            n_checks++;
            if (bus.moving !== 1'b1 || bus.door_open !== 1'b0 ||
                int'(bus.floor_idx) !== ((k <= TRAVEL) ? 0 : 1) || bus.pending[2] !== 1'b1) begin
                n_errors++;
                $display("FAIL travel_c%0d: mov=%0b door=%0b idx=%0d pend2=%0b, required 1/0/%0d/1",
                         k, bus.moving, bus.door_open, bus.floor_idx, bus.pending[2], (k <= TRAVEL) ? 0 : 1);
            end
        end
        step();
        n_checks++;
        if (bus.floor_idx !== 2'd2 || bus.door_open !== 1'b1 || bus.moving !== 1'b0 || bus.pending !== 4'b0000) begin
            n_errors++;
            $display("FAIL travel_arrive: idx=%0d door=%0b mov=%0b pend=%b, required 2/1/0/0000",
                     bus.floor_idx, bus.door_open, bus.moving, bus.pending);
        end
        repeat (DOOR) step();
        n_checks++;
        if (bus.door_open !== 1'b0 || bus.moving !== 1'b0) begin
            n_errors++;
            $display("FAIL travel_close: door=%0b mov=%0b, required 0/0", bus.door_open, bus.moving);
        end
    endtask

    task automatic test_extend();
        bus.call_req = 4'b0100;
        exp_q.push_back(2);
        step();               // open cycle 1
        bus.call_req = '0;
        step();               // open cycle 2
        bus.call_req = 4'b0100;
        for (int k = 2; k <= 5; k++) begin
            n_checks++;
            if (bus.door_open !== (k <= 4) || bus.pending[2] !== 1'b0) begin
                n_errors++;
                $display("FAIL extend_c%0d: door=%0b pend2=%0b, required %0b/0", k, bus.door_open, bus.pending[2], (k <= 4));
            end
            step();
            bus.call_req = '0;
        end
    endtask

    task automatic test_sweep();
        bit pulsed;
        bit done;
        apply_reset();
        bus.call_req = 4'b1000;
        exp_q.push_back(3);
        exp_q.push_back(0);
        pulsed = 1'b0;
        done   = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            step();
            bus.call_req = '0;
            if (!pulsed && bus.moving && bus.floor_idx == 2'd1 && bus.dir_up) begin
                bus.call_req = 4'b0001;
                pulsed = 1'b1;
            end
            if (bus.door_open && bus.floor_idx == 2'd0) done = 1'b1;
        end
        n_checks++;
        if (!done || bus.dir_up !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sweep_reverse: reached0=%0b dir_up=%0b left_in_queue=%0d, required 1/0/0",
                     done, bus.dir_up, exp_q.size());
        end
        repeat (DOOR + 1) step();
    endtask

    task automatic test_reset_mid_move();
        bit found;
        bus.call_req = 4'b1100;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            bus.call_req = '0;
            if (bus.moving && bus.floor_idx == 2'd1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL mid_move_reach: car never moving at floor 1, required within 40 cycles");
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_checks++;
        if (bus.floor_idx !== 2'd0 || bus.moving !== 1'b0 || bus.pending !== 4'b0000 || bus.door_open !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_move_reset: idx=%0d mov=%0b pend=%b door=%0b, required 0/0/0000/0",
                     bus.floor_idx, bus.moving, bus.pending, bus.door_open);
        end
        repeat (5) step();
        n_checks++;
        if (bus.moving !== 1'b0 || bus.door_open !== 1'b0 || bus.floor_idx !== 2'd0) begin
            n_errors++;
            $display("FAIL calls_lost: mov=%0b door=%0b idx=%0d, required 0/0/0", bus.moving, bus.door_open, bus.floor_idx);
        end
    endtask

    task automatic test_random_traffic();
        apply_reset();
        sb_strict   = 1'b0;
        outstanding = '0;
        for (int c = 0; c < 600; c++) begin
            step();
            bus.call_req = '0;
            if ($urandom_range(0, 7) == 0) begin
                int f;
                f = $urandom_range(0, N - 1);
                // Avoid re-pressing the open floor so the door cannot be held indefinitely.
                if (!(bus.door_open && int'(bus.floor_idx) == f)) begin
                    bus.call_req[f] = 1'b1;
                    if (!outstanding[f]) age[f] = 0;
                    outstanding[f] = 1'b1;
                end
            end
        end
        step();
        bus.call_req = '0;
        repeat (SERVE_BOUND + 10) step();
        n_checks++;
        if (outstanding !== '0 || bus.pending !== '0) begin
            n_errors++;
            $display("FAIL random_drain: outstanding=%b pending=%b, required 0000/0000", outstanding, bus.pending);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) age[i] = 0;
        rst_n = 1'b0;
        bus.call_req = '0;
        test_reset();
        test_call_at_floor();
        test_travel();
        test_extend();
        test_sweep();
        test_reset_mid_move();
        test_random_traffic();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: %0d expected openings never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
